// File: rtl/serial_pair_sched_pkg.sv
// Shared encodings and size defaults for the serial pair scheduler.
package serial_pair_sched_pkg;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    DET_LOW  = 1'b0,
    DET_HIGH = 1'b1
  } det_t;

endpackage

// File: rtl/serial_pair_sched_pair_detect.sv
// Two-state Mealy detector: flags each bit that is a 1 following a 1.
module pair_detect
  import serial_pair_sched_pkg::*;
(
  input  logic clk,
  input  logic areset,
  input  logic clr,
  input  logic bit_in,
  output logic hit
);

  det_t st_r;

  // Detector state follows the previous bit; clr forces LOW between frames.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      st_r <= DET_LOW;
    end else if (clr) begin
      st_r <= DET_LOW;
    end else begin
      st_r <= bit_in ? DET_HIGH : DET_LOW;
    end
  end

  assign hit = (st_r == DET_HIGH) && bit_in;

endmodule

// File: rtl/serial_pair_sched.sv
// Round-robin two-requester scheduler that serialises the granted frame
// LSB first through a pair detector and reports the "11" pair count.
module serial_pair_sched
  import serial_pair_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
)
(
  input  logic          clk,
  input  logic          areset,
  input  logic [1:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [1:0]    done,
  output logic [CW-1:0] match_cnt
);

  state_t        state_r;
  logic [DW-1:0] data_r;
  logic [CW-1:0] idx_r;
  logic [CW-1:0] acc_r;
  logic          ptr_r;
  logic          sel_r;
  logic          win_s;
  logic          bit_s;
  logic          hit_s;
  logic          clr_s;

  // Round-robin pick: a tie goes to the requester not served last.
  always_comb begin
    win_s = 1'b0;
    if (req == 2'b11) begin
      win_s = ~ptr_r;
    end else begin
      win_s = req[1];
    end
  end

  assign bit_s = data_r[idx_r];
  assign clr_s = (state_r != ST_SHIFT);

  pair_detect u_detect (
    .clk    (clk),
    .areset (areset),
    .clr    (clr_s),
    .bit_in (bit_s),
    .hit    (hit_s)
  );

  // Frame FSM with all outputs registered; DONE's effects land on its exit edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      data_r    <= '0;
      idx_r     <= '0;
      acc_r     <= '0;
      ptr_r     <= 1'b1;
      sel_r     <= 1'b0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done      <= 2'b00;
      match_cnt <= '0;
    end else begin
      done <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            sel_r   <= win_s;
            gnt     <= win_s ? 2'b10 : 2'b01;
            data_r  <= win_s ? data1 : data0;
            idx_r   <= '0;
            acc_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (hit_s && (acc_r != CW'(DW - 1))) begin
            acc_r <= acc_r + 1'b1;
          end
          if (idx_r == CW'(DW - 1)) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= sel_r ? 2'b10 : 2'b01;
          match_cnt <= acc_r;
          ptr_r     <= sel_r;
          gnt       <= 2'b00;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          gnt     <= 2'b00;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pair_sched.sv
// Randomised self-checking bench for serial_pair_sched against a frame-level model.
module tb_serial_pair_sched;
  import serial_pair_sched_pkg::*;

  localparam int DW = DW_DEF;
  localparam int CW = CW_DEF;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] data0 = '0;
  logic [DW-1:0] data1 = '0;
  logic [1:0]    gnt;
  logic          busy;
  logic [1:0]    done;
  logic [CW-1:0] match_cnt;

  int            checks = 0;
  int            errors = 0;
  logic          ptr_m = 1'b1;
  logic [CW-1:0] last_cnt_m = '0;

  always #5 clk = ~clk;

  serial_pair_sched #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .areset    (areset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  // Count adjacent 1-1 pairs in the frame, capped at DW-1.
  function automatic int pairs(input logic [DW-1:0] d);
    int n = 0;
    for (int i = 1; i < DW; i++) if (d[i] && d[i-1]) n++;
    if (n > DW - 1) n = DW - 1;
    return n;
  endfunction

  function automatic logic pick(input logic [1:0] r, input logic p);
    if (r == 2'b11) return ~p;
    return r[1];
  endfunction

  // Observes one frame starting at a negedge with req already driven.
  task automatic run_frame(input int drop_at, input logic [1:0] req_after, input bit scramble,
                           output int wait_cyc, output logic [1:0] g, output logic [CW-1:0] mc_mid,
                           output int busy_cyc, output bit stable, output logic [1:0] d,
                           output logic [CW-1:0] mc, output bit to);
    to = 1'b0; wait_cyc = 0; busy_cyc = 0; stable = 1'b1;
    g = 2'b00; d = 2'b00; mc = '0; mc_mid = '0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (gnt == 2'b00 && wait_cyc < 20);
    if (gnt == 2'b00) begin
      to = 1'b1;
      return;
    end
    g = gnt;
    mc_mid = match_cnt;
    if (scramble) begin
      data0 = DW'($urandom);
      data1 = DW'($urandom);
    end
    while (busy && busy_cyc < 4 * DW) begin
      busy_cyc++;
      if (gnt !== g || done !== 2'b00) stable = 1'b0;
      if (busy_cyc == drop_at) req = req_after;
      @(negedge clk);
    end
    if (busy) begin
      to = 1'b1;
      return;
    end
    d = done;
    mc = match_cnt;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, busy, done, match_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b busy=%b done=%b cnt=%0d exp all 0", gnt, busy, done, match_cnt);
    end
    areset = 1'b0;
    ptr_m = 1'b1;
    last_cnt_m = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy=%b gnt=%b exp 0/00", busy, gnt);
    end
  endtask

  task automatic test_single();
    int w, bc; logic [1:0] g, d; logic [CW-1:0] mm, mc; bit st, to;
    data0 = 8'hFF;
    data1 = 8'h00;
    req = 2'b01;
    run_frame(3, 2'b00, 1'b0, w, g, mm, bc, st, d, mc, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout got timeout exp frame"); end
    checks++;
    if (w !== 1 || g !== 2'b01) begin
      errors++; $display("FAIL single_grant got wait=%0d gnt=%b exp 1/01", w, g);
    end
    checks++;
    if (bc !== DW + 1 || !st) begin
      errors++; $display("FAIL single_busy got busy_cycles=%0d stable=%0d exp %0d/1", bc, st, DW + 1);
    end
    checks++;
    if (d !== 2'b01 || mc !== CW'(DW - 1)) begin
      errors++; $display("FAIL single_done got done=%b cnt=%0d exp 01/%0d", d, mc, DW - 1);
    end
    ptr_m = 1'b0;
    last_cnt_m = mc;
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse got done=%b busy=%b exp 00/0", done, busy);
    end
  endtask

  task automatic test_patterns();
    logic [DW-1:0] pats [3];
    int w, bc; logic [1:0] g, d; logic [CW-1:0] mm, mc; bit st, to;
    pats[0] = 8'b0011_0011;
    pats[1] = 8'h55;
    pats[2] = 8'b1110_1101;
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      data0 = pats[i];
      run_frame(0, 2'b00, 1'b1, w, g, mm, bc, st, d, mc, to);
      checks++;
      if (to || g !== 2'b01 || d !== 2'b01 || mc !== CW'(pairs(pats[i])) || mm !== last_cnt_m) begin
        errors++;
        $display("FAIL pattern_%0d got to=%0d gnt=%b done=%b cnt=%0d held=%0d exp 01/01/%0d/%0d",
                 i, to, g, d, mc, mm, pairs(pats[i]), last_cnt_m);
      end
      last_cnt_m = CW'(pairs(pats[i]));
    end
    ptr_m = 1'b0;
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_alternation();
    int w, bc; logic [1:0] g, d, eg; logic [CW-1:0] mm, mc; bit st, to; logic win;
    logic [DW-1:0] ed;
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    ptr_m = 1'b1;
    last_cnt_m = '0;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      data0 = DW'($urandom);
      data1 = DW'($urandom);
      win = pick(req, ptr_m);
      ed = win ? data1 : data0;
      eg = win ? 2'b10 : 2'b01;
      run_frame(0, 2'b00, 1'b0, w, g, mm, bc, st, d, mc, to);
      checks++;
      if (to || w !== 1 || g !== eg || d !== eg || mc !== CW'(pairs(ed))) begin
        errors++;
        $display("FAIL alternation_%0d got to=%0d wait=%0d gnt=%b done=%b cnt=%0d exp 1/%b/%b/%0d",
                 i, to, w, g, d, mc, eg, eg, pairs(ed));
      end
      ptr_m = win;
      last_cnt_m = CW'(pairs(ed));
    end
    checks++;
    if (ptr_m !== 1'b0) begin
      errors++; $display("FAIL alternation_order got last=%0d exp 0", ptr_m);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w, bc; logic [1:0] g, d; logic [CW-1:0] mm, mc; bit st, to;
    req = 2'b01;
    data0 = 8'h80;
    run_frame(0, 2'b00, 1'b0, w, g, mm, bc, st, d, mc, to);
    checks++;
    if (to || d !== 2'b01 || mc !== 3'd0) begin
      errors++; $display("FAIL b2b_first got to=%0d done=%b cnt=%0d exp 01/0", to, d, mc);
    end
    data0 = 8'h01;
    run_frame(0, 2'b00, 1'b0, w, g, mm, bc, st, d, mc, to);
    checks++;
    if (to || w !== 1 || d !== 2'b01 || mc !== 3'd0) begin
      errors++; $display("FAIL b2b_second got to=%0d wait=%0d done=%b cnt=%0d exp 1/01/0", to, w, d, mc);
    end
    ptr_m = 1'b0;
    last_cnt_m = '0;
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    int w, bc; logic [1:0] g, d; logic [CW-1:0] mm, mc; bit st, to;
    req = 2'b01;
    data0 = 8'hFF;
    run_frame(2, 2'b00, 1'b1, w, g, mm, bc, st, d, mc, to);
    checks++;
    if (to || bc !== DW + 1 || !st || d !== 2'b01 || mc !== CW'(DW - 1)) begin
      errors++;
      $display("FAIL drop_req got to=%0d busy_cycles=%0d stable=%0d done=%b cnt=%0d exp %0d/1/01/%0d",
               to, bc, st, d, mc, DW + 1, DW - 1);
    end
    ptr_m = 1'b0;
    last_cnt_m = mc;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w, bc, n; logic [1:0] g, d; logic [CW-1:0] mm, mc; bit st, to; bit saw_done;
    req = 2'b01;
    data0 = 8'hFF;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL midreset_grant got gnt=%b exp 01", gnt); end
    repeat (4) @(negedge clk);
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, done, match_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got gnt=%b busy=%b done=%b cnt=%0d exp all 0", gnt, busy, done, match_cnt);
    end
    @(negedge clk);
    areset = 1'b0;
    req = 2'b00;
    ptr_m = 1'b1;
    last_cnt_m = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 2'b00 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midreset_no_done got activity=1 exp 0"); end
    req = 2'b11;
    data0 = 8'hFF;
    data1 = 8'h00;
    run_frame(1, 2'b00, 1'b0, w, g, mm, bc, st, d, mc, to);
    checks++;
    if (to || g !== 2'b01 || d !== 2'b01 || mc !== CW'(DW - 1) || mm !== 3'd0) begin
      errors++;
      $display("FAIL midreset_recover got to=%0d gnt=%b done=%b cnt=%0d held=%0d exp 01/01/%0d/0",
               to, g, d, mc, mm, DW - 1);
    end
    ptr_m = 1'b0;
    last_cnt_m = mc;
  endtask

  task automatic test_random();
    int w, bc; logic [1:0] g, d, eg, r; logic [CW-1:0] mm, mc; bit st, to; logic win;
    logic [DW-1:0] ed;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 2'b00;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      r = 2'($urandom_range(1, 3));
      req = r;
      data0 = DW'($urandom);
      data1 = DW'($urandom);
      win = pick(r, ptr_m);
      ed = win ? data1 : data0;
      eg = win ? 2'b10 : 2'b01;
      run_frame($urandom_range(0, DW), 2'($urandom_range(0, 3)), 1'b1, w, g, mm, bc, st, d, mc, to);
      checks++;
      if (to || w !== 1 || g !== eg || bc !== DW + 1 || !st) begin
        errors++;
        $display("FAIL random_%0d_frame got to=%0d wait=%0d gnt=%b busy_cycles=%0d stable=%0d exp 1/%b/%0d/1",
                 i, to, w, g, bc, st, eg, DW + 1);
      end
      checks++;
      if (d !== eg || mc !== CW'(pairs(ed)) || mm !== last_cnt_m) begin
        errors++;
        $display("FAIL random_%0d_result got done=%b cnt=%0d held=%0d exp %b/%0d/%0d",
                 i, d, mc, mm, eg, pairs(ed), last_cnt_m);
      end
      ptr_m = win;
      last_cnt_m = CW'(pairs(ed));
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_alternation();
    test_back_to_back();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pair_sched.md
SERIAL_PAIR_SCHED -- requirements
Module: serial_pair_sched

Interface
REQ-001 Parameter: DW, default 8, frame length in bits per request.
REQ-002 Parameter: CW, default 3, width of the bit index and match count, equal to clog2(DW).
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: areset  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  2  per-requester level request, index 0 and 1.
REQ-006 Port: data0  input  DW  requester-0 frame, latched at grant.
REQ-007 Port: data1  input  DW  requester-1 frame, latched at grant.
REQ-008 Port: gnt  output  2  one-hot grant, held from grant through DONE.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  2  one-cycle pulse to the served requester.
REQ-011 Port: match_cnt  output  CW  match count of the last completed frame, held until the next DONE.

Function
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE, registered and updated on clk.
REQ-013 IDLE: with any req bit high at a clk edge, the block SHALL grant one requester, latch its data, clear the bit index, match accumulator and detector, and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin with a 1-bit last-served pointer.
- If both req bits are high, the requester not last served wins.
- If one req bit is high, that requester wins regardless of the pointer.
REQ-015 SHIFT SHALL present one latched bit per cycle, LSB first, to the detector for exactly DW cycles (index 0 to DW-1), then enter DONE.
REQ-016 The detector SHALL be a two-state Mealy machine (LOW, HIGH).
- Next state: HIGH if the bit is 1, else LOW.
- Output: 1 only when the state is HIGH and the current bit is 1, so overlapping "11" pairs each count.
REQ-017 The accumulator SHALL increment by one on each SHIFT cycle whose detector output is 1; the maximum is DW-1 and it never wraps.
REQ-018 DONE SHALL last one cycle.
- Pulse done[g], where g is the granted index.
- Register the accumulator into match_cnt.
- Update the pointer to g.
- Drop gnt and return to IDLE.
REQ-019 Latency: req sampled at edge N gives gnt high after N, SHIFT on cycles N+1 to N+DW, and done high for the cycle after edge N+DW+1.
REQ-020 req changes, including deassertion, during SHIFT or DONE SHALL NOT abort or alter the frame.
REQ-021 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-022 Detector state SHALL NOT carry across frames: it is cleared at every grant.

Reset
REQ-023 areset SHALL immediately force:
- state IDLE, gnt 0, busy 0, done 0, match_cnt 0;
- pointer to requester 1, so requester 0 wins the first tie;
- detector LOW and bit index 0.
REQ-024 areset asserted mid-frame SHALL discard the frame without issuing done.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the detector state encoding, and the DW/CW defaults.
REQ-026 The Mealy detector SHALL be a separate sub-module, pair_detect, with inputs clk, areset, clr and bit_in, and output hit.

Verification
REQ-027 Reset, then req=01 with data0=8'hFF -> gnt=01, DW shift cycles, done=01 pulse, match_cnt=7.
REQ-028 data0=8'b0011_0011 (bits LSB first 1,1,0,0,1,1,0,0) -> match_cnt=2; data0=8'h55 -> match_cnt=0.
REQ-029 req=11 held after reset -> requester 0 served first, requester 1 second, requester 0 third (alternation).
REQ-030 Back-to-back frames 8'h80 then 8'h01 from requester 0 -> match_cnt=0 both times (no cross-frame match).
REQ-031 areset pulsed at SHIFT bit 4 -> all outputs 0 immediately, no done; next request completes normally.
REQ-032 req0 dropped during SHIFT -> frame completes, done=01 delivered.
